// File: rtl/calc_key_collector.sv
// Key-event collector: builds operand_1 / operator / operand_2 from keypad strobes and runs the assembler enable window.
// Every key takes effect on its own edge (1-cycle latency); there is no backpressure, so keys outside the legal grammar are ignored or force ERROR.
module calc_key_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIGITS = 3,
  parameter int ASM_CYCLES = 17,
  parameter int KEY_ENTER  = 24,
  parameter int KEY_CLEAR  = 25
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  output logic [DATA_WIDTH-1:0] operand_1,
  output logic [7:0]            operator,
  output logic [DATA_WIDTH-1:0] operand_2,
  output logic                  assembler_enable,
  output logic                  busy,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  localparam int ACC_W = DATA_WIDTH + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int CYC_W = (ASM_CYCLES > 1) ? $clog2(ASM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX_DIG_C = CNT_W'(MAX_DIGITS);
  localparam logic [CYC_W-1:0] ASM_LAST  = CYC_W'(ASM_CYCLES - 1);
  localparam logic [ACC_W-1:0] MAX_VAL   = ACC_W'({DATA_WIDTH{1'b1}});

  typedef enum logic [2:0] {
    ST_OP1  = 3'd0,
    ST_OP2  = 3'd1,
    ST_ASM  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] operand_1_q, operand_1_d;
  logic [DATA_WIDTH-1:0] operand_2_q, operand_2_d;
  logic [7:0]            operator_q, operator_d;
  logic [CNT_W-1:0]      digit_count_q, digit_count_d;
  logic [CYC_W-1:0]      cycle_q, cycle_d;
  logic                  enable_q, enable_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  logic                  is_digit, is_op, is_enter, is_clear, digit_ok;
  logic [DATA_WIDTH-1:0] cur_operand;
  logic [ACC_W-1:0]      acc_new;

  assign is_digit = (key_code <= 8'd9);
  assign is_op    = (key_code >= 8'd20) && (key_code <= 8'd23);
  assign is_enter = (key_code == 8'(KEY_ENTER));
  assign is_clear = (key_code == 8'(KEY_CLEAR));

  // Widened so cur*10+d never wraps before the range test.
  assign cur_operand = (state_q == ST_OP2) ? operand_2_q : operand_1_q;
  assign acc_new     = ACC_W'(cur_operand) * ACC_W'(10) + ACC_W'(key_code[3:0]);
  assign digit_ok    = (digit_count_q < MAX_DIG_C) && (acc_new <= MAX_VAL);

  always_comb begin
    state_d       = state_q;
    operand_1_d   = operand_1_q;
    operand_2_d   = operand_2_q;
    operator_d    = operator_q;
    digit_count_d = digit_count_q;
    cycle_d       = cycle_q;

    if (state_q == ST_ASM) begin
      if (cycle_q == ASM_LAST) begin
        state_d = ST_DONE;
        cycle_d = '0;
      end else begin
        cycle_d = cycle_q + CYC_W'(1);
      end
    end

    if (key_valid) begin
      if (is_clear) begin
        state_d       = ST_OP1;
        operand_1_d   = '0;
        operand_2_d   = '0;
        operator_d    = '0;
        digit_count_d = '0;
        cycle_d       = '0;
      end else begin
        case (state_q)
          ST_OP1: begin
            if (is_digit) begin
              if (digit_ok) begin
                operand_1_d   = acc_new[DATA_WIDTH-1:0];
                digit_count_d = digit_count_q + CNT_W'(1);
              end else begin
                state_d = ST_ERR;
              end
            end else if (is_op) begin
              if (digit_count_q == '0) begin
                state_d = ST_ERR;
              end else begin
                operator_d    = key_code;
                digit_count_d = '0;
                state_d       = ST_OP2;
              end
            end else if (is_enter) begin
              state_d = ST_ERR;
            end
          end
          ST_OP2: begin
            if (is_digit) begin
              if (digit_ok) begin
                operand_2_d   = acc_new[DATA_WIDTH-1:0];
                digit_count_d = digit_count_q + CNT_W'(1);
              end else begin
                state_d = ST_ERR;
              end
            end else if (is_op) begin
              state_d = ST_ERR;
            end else if (is_enter) begin
              if ((digit_count_q == '0) ||
                  ((operator_q == 8'd23) && (operand_2_q == '0))) begin
                state_d = ST_ERR;
              end else begin
                state_d = ST_ASM;
                cycle_d = '0;
              end
            end
          end
          ST_DONE: begin
            // A fresh digit starts a new expression in place of the held one.
            if (is_digit) begin
              operand_1_d   = DATA_WIDTH'(key_code[3:0]);
              operand_2_d   = '0;
              operator_d    = '0;
              digit_count_d = CNT_W'(1);
              state_d       = ST_OP1;
            end
          end
          default: ;
        endcase
      end
    end

    enable_d = (state_d == ST_ASM);
    busy_d   = (state_d == ST_ASM);
    error_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_OP1;
      operand_1_q   <= '0;
      operand_2_q   <= '0;
      operator_q    <= '0;
      digit_count_q <= '0;
      cycle_q       <= '0;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      operand_1_q   <= operand_1_d;
      operand_2_q   <= operand_2_d;
      operator_q    <= operator_d;
      digit_count_q <= digit_count_d;
      cycle_q       <= cycle_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
    end
  end

  assign operand_1        = operand_1_q;
  assign operand_2        = operand_2_q;
  assign operator         = operator_q;
  assign assembler_enable = enable_q;
  assign busy             = busy_q;
  assign error            = error_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_calc_key_collector.sv
// Bench for calc_key_collector: directed test-plan scenarios plus random key streams against an expression-level model.
module tb_calc_key_collector;

  localparam int S_OP1  = 0;
  localparam int S_OP2  = 1;
  localparam int S_ASM  = 2;
  localparam int S_DONE = 3;
  localparam int S_ERR  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'd0;
  logic [7:0] operand_1, operator, operand_2;
  logic       assembler_enable, busy, error;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: expression being typed, plus how many enable cycles remain.
  int m_state, m_op1, m_op2, m_opr, m_digits, m_left;

  calc_key_collector dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .operand_1(operand_1), .operator(operator), .operand_2(operand_2),
    .assembler_enable(assembler_enable), .busy(busy), .error(error),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  function automatic void m_clear();
    m_state = S_OP1; m_op1 = 0; m_op2 = 0; m_opr = 0; m_digits = 0; m_left = 0;
  endfunction

  function automatic void m_step(input bit v, input int code);
    int prev, nv;
    prev = m_state;
    if (prev == S_ASM) begin
      m_left--;
      if (m_left == 0) m_state = S_DONE;
    end
    if (!v) return;
    if (code == 25) begin
      m_clear();
      return;
    end
    if (code <= 9 && (prev == S_OP1 || prev == S_OP2)) begin
      nv = ((prev == S_OP1) ? m_op1 : m_op2) * 10 + code;
      if (m_digits >= 3 || nv > 255) m_state = S_ERR;
      else begin
        if (prev == S_OP1) m_op1 = nv; else m_op2 = nv;
        m_digits++;
      end
    end else if (code <= 9 && prev == S_DONE) begin
      m_op1 = code; m_op2 = 0; m_opr = 0; m_digits = 1; m_state = S_OP1;
    end else if (code >= 20 && code <= 23) begin
      if (prev == S_OP1) begin
        if (m_digits == 0) m_state = S_ERR;
        else begin m_opr = code; m_digits = 0; m_state = S_OP2; end
      end else if (prev == S_OP2) m_state = S_ERR;
    end else if (code == 24) begin
      if (prev == S_OP1) m_state = S_ERR;
      else if (prev == S_OP2) begin
        if (m_digits == 0 || (m_opr == 23 && m_op2 == 0)) m_state = S_ERR;
        else begin m_state = S_ASM; m_left = 17; end
      end
    end
  endfunction

  function automatic logic [29:0] exp_vec();
    logic [31:0] a, b, c;
    a = m_op1; b = m_opr; c = m_op2;
    return {a[7:0], b[7:0], c[7:0], m_state == S_ASM, m_state == S_ASM,
            m_state == S_ERR, 3'(m_state)};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {operand_1, operator, operand_2, assembler_enable, busy, error, state_dbg};
  endfunction

  task automatic press(input int code);
    key_valid = 1'b1;
    key_code  = 8'(code);
    m_step(1'b1, code);
    @(posedge clock); #1;
    key_valid = 1'b0;
    key_code  = 8'($urandom);
  endtask

  task automatic idle();
    m_step(1'b0, 0);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b1; key_code = 8'd3;
    repeat (3) @(posedge clock);
    #1;
    m_clear();
    reset = 1'b0; key_valid = 1'b0;
    checks++;
    if (dut_vec() !== 30'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), 30'd0);
    end
  endtask

  task automatic test_basic_expression();
    int n;
    press(1); press(2); press(20); press(3); press(4);
    checks++;
    if ({operand_1, operator, operand_2, state_dbg} !== {8'd12, 8'd20, 8'd34, 3'd1}) begin
      errors++; $display("FAIL tp1_operands got=%0d %0d %0d st%0d exp=12 20 34 st1",
                         operand_1, operator, operand_2, state_dbg);
    end
    press(24);
    checks++;
    if (assembler_enable !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL tp1_enable_latency got=%b%b exp=11", assembler_enable, busy);
    end
    n = 0;
    while (assembler_enable === 1'b1 && n < 40) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL tp1_assemble got=%h exp=%h", dut_vec(), exp_vec());
      end
      n++;
      idle();
    end
    checks++;
    if (n != 17) begin
      errors++; $display("FAIL tp1_enable_width got=%0d exp=17", n);
    end
    checks++;
    if ({operand_1, operator, operand_2, state_dbg, busy} !== {8'd12, 8'd20, 8'd34, 3'd3, 1'b0}) begin
      errors++; $display("FAIL tp1_done_hold got=%0d %0d %0d st%0d exp=12 20 34 st3",
                         operand_1, operator, operand_2, state_dbg);
    end
  endtask

  task automatic test_max_and_overflow();
    press(25);
    press(2); press(5); press(5); press(22); press(2); press(24);
    checks++;
    if ({operand_1, operator, operand_2, busy} !== {8'd255, 8'd22, 8'd2, 1'b1}) begin
      errors++; $display("FAIL tp2_max_accept got=%0d %0d %0d b%b exp=255 22 2 b1",
                         operand_1, operator, operand_2, busy);
    end
    repeat (20) idle();
    press(2); press(5);
    checks++;
    if (error !== 1'b0 || operand_1 !== 8'd25) begin
      errors++; $display("FAIL tp2_pre_overflow got=e%b %0d exp=e0 25", error, operand_1);
    end
    press(6);
    checks++;
    if ({error, operand_1, state_dbg} !== {1'b1, 8'd25, 3'd4}) begin
      errors++; $display("FAIL tp2_overflow got=e%b %0d st%0d exp=e1 25 st4", error, operand_1, state_dbg);
    end
    press(25);
    checks++;
    if (dut_vec() !== 30'd0) begin
      errors++; $display("FAIL tp2_clear got=%h exp=%h", dut_vec(), 30'd0);
    end
  endtask

  task automatic test_malformed();
    press(0); press(0); press(1);
    checks++;
    if (error !== 1'b0 || operand_1 !== 8'd1) begin
      errors++; $display("FAIL tp3_three_digits got=e%b %0d exp=e0 1", error, operand_1);
    end
    press(2);
    checks++;
    if (error !== 1'b1 || state_dbg !== 3'd4) begin
      errors++; $display("FAIL tp3_fourth_digit got=e%b st%0d exp=e1 st4", error, state_dbg);
    end
    press(25); press(20);
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL tp3_leading_op got=%b exp=1", error);
    end
    press(25); press(7); press(23); press(0); press(24);
    checks++;
    if (error !== 1'b1 || state_dbg !== 3'd4) begin
      errors++; $display("FAIL tp3_div_zero got=e%b st%0d exp=e1 st4", error, state_dbg);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (assembler_enable !== 1'b0) begin
        errors++; $display("FAIL tp3_no_enable got=%b exp=0 cyc=%0d", assembler_enable, i);
      end
      idle();
    end
    press(25);
  endtask

  task automatic test_clear_mid_assemble();
    press(9); press(21); press(3); press(24);
    repeat (4) idle();
    checks++;
    if (assembler_enable !== 1'b1) begin
      errors++; $display("FAIL tp4_fifth_cycle got=%b exp=1", assembler_enable);
    end
    press(25);
    checks++;
    if (dut_vec() !== 30'd0) begin
      errors++; $display("FAIL tp4_clear_asm got=%h exp=%h", dut_vec(), 30'd0);
    end
    press(5);
    for (int i = 0; i < 12; i++) begin
      key_valid = 1'b0;
      key_code  = (i % 3 == 0) ? 8'd25 : (i % 3 == 1) ? 8'd24 : 8'($urandom_range(0, 23));
      idle();
    end
    checks++;
    if ({operand_1, state_dbg, error} !== {8'd5, 3'd0, 1'b0} || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL tp4_invalid_ignored got=%h exp=%h", dut_vec(), exp_vec());
    end
    press(25);
  endtask

  task automatic test_done_restart_and_reset();
    press(6); press(20); press(7); press(24);
    repeat (17) idle();
    checks++;
    if (state_dbg !== 3'd3) begin
      errors++; $display("FAIL tp5_done got=%0d exp=3", state_dbg);
    end
    press(4);
    checks++;
    if ({operand_1, operand_2, operator, state_dbg} !== {8'd4, 8'd0, 8'd0, 3'd0}) begin
      errors++; $display("FAIL tp5_restart got=%0d %0d %0d st%0d exp=4 0 0 st0",
                         operand_1, operand_2, operator, state_dbg);
    end
    press(22); press(3);
    reset = 1'b1; key_valid = 1'b1; key_code = 8'd5;
    m_clear();
    @(posedge clock); #1;
    reset = 1'b0; key_valid = 1'b0;
    checks++;
    if (dut_vec() !== 30'd0) begin
      errors++; $display("FAIL tp5_reset_priority got=%h exp=%h", dut_vec(), 30'd0);
    end
  endtask

  task automatic test_random();
    int r, code;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        key_valid = 1'b0; key_code = 8'($urandom);
        idle();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 60) code = $urandom_range(0, 9);
        else if (r < 75) code = $urandom_range(20, 23);
        else if (r < 87) code = 24;
        else if (r < 93) code = 25;
        else code = $urandom_range(10, 19);
        press(code);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_step%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_basic_expression();
    test_max_and_overflow();
    test_malformed();
    test_clear_mid_assemble();
    test_done_restart_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
